data_bus_responder: RTL and testbench



---
 rtl/dbr_pkg.sv | 24 ++
 rtl/dbr_timer.sv | 107 ++++++++++
 rtl/data_bus_responder.sv | 84 ++++++++
 tb/tb_data_bus_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dbr_pkg.sv
// Shared definitions for the data-bus responder: timer register map, CTRL fields, FSM states.
package dbr_pkg;

    // Timer register word offsets from TIMER_BASE
    localparam logic [1:0] RegCtrl   = 2'd0;
    localparam logic [1:0] RegPreset = 2'd1;
    localparam logic [1:0] RegCount  = 2'd2;

    // CTRL bit positions
    localparam int unsigned CtrlEn      = 0;
    localparam int unsigned CtrlModeLsb = 1;
    localparam int unsigned CtrlIm      = 3;

    // MODE encoding; every other code behaves as one-shot
    localparam logic [1:0] ModeAutoReload = 2'b01;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCnt,
        StInt
    } timer_state_e;

endpackage

// File: rtl/dbr_timer.sv
// Countdown timer peripheral: CTRL/PRESET/COUNT registers, run FSM, pending flag and level irq.
module dbr_timer
    import dbr_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        we_i,
    input  logic [1:0]  sel_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        irq_o
);

    timer_state_e state_q, state_d;
    logic [3:0]   ctrl_q, ctrl_d;
    logic [31:0]  preset_q, preset_d;
    logic [31:0]  count_q, count_d;
    logic         pending_q, pending_d;
    logic         en;
    logic         auto_reload;

    assign en          = ctrl_q[CtrlEn];
    assign auto_reload = (ctrl_q[CtrlModeLsb +: 2] == ModeAutoReload);

    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        preset_d  = preset_q;
        count_d   = count_q;
        pending_d = pending_q;

        unique case (state_q)
            StIdle: begin
                if (en) begin
                    // COUNT is already valid on the edge that enters LOAD
                    count_d = preset_q;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                count_d = preset_q;
                state_d = StCnt;
            end
            StCnt: begin
                if (!en) begin
                    state_d = StIdle;
                end else if (count_q <= 32'd1) begin
                    count_d   = '0;
                    pending_d = 1'b1;
                    state_d   = StInt;
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            StInt: begin
                pending_d = 1'b1;
                if (auto_reload) begin
                    state_d = StLoad;
                end else begin
                    ctrl_d[CtrlEn] = 1'b0;
                    state_d        = StIdle;
                end
            end
        endcase

        // Bus writes take priority over hardware updates on the same edge
        if (we_i) begin
            case (sel_i)
                RegCtrl: begin
                    ctrl_d    = wdata_i[3:0];
                    pending_d = 1'b0;
                end
                RegPreset: preset_d = wdata_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            ctrl_q    <= '0;
            preset_q  <= '0;
            count_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        case (sel_i)
            RegCtrl:   rdata_o = {28'd0, ctrl_q};
            RegPreset: rdata_o = preset_q;
            RegCount:  rdata_o = count_q;
            default:   rdata_o = '0;
        endcase
    end

    assign irq_o = pending_q & ctrl_q[CtrlIm];

endmodule

// File: rtl/data_bus_responder.sv
// CPU data-bus responder: word RAM with byte-enabled writes plus optional timer.
// The timer and its decode are built only when DBR_TIMER_EN is defined.
module data_bus_responder
    import dbr_pkg::*;
#(
    parameter int unsigned DM_WORDS   = 3072,
    parameter logic [31:0] TIMER_BASE = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_data_addr,
    input  logic [31:0] m_data_wdata,
    input  logic [3:0]  m_data_byteen,
    input  logic [31:0] m_inst_addr,
    output logic [31:0] m_data_rdata,
    output logic        irq
);

    localparam int unsigned AW       = $clog2(DM_WORDS);
    localparam logic [31:0] RamBytes = 32'(4 * DM_WORDS);

    logic [31:0]   mem_q [DM_WORDS];
    logic          ram_hit;
    logic [AW-1:0] ram_idx;
    logic          tmr_hit;
    logic [31:0]   tmr_rdata;
    logic          unused_inst;

    // The instruction address only feeds an optional trace path
    assign unused_inst = ^m_inst_addr;

    assign ram_hit = (m_data_addr < RamBytes);
    assign ram_idx = m_data_addr[AW+1:2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (ram_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (m_data_byteen[b]) begin
                    mem_q[ram_idx][8*b +: 8] <= m_data_wdata[8*b +: 8];
                end
            end
        end
    end

`ifdef DBR_TIMER_EN
    logic [29:0] tmr_off;
    logic        tmr_we;

    assign tmr_off = m_data_addr[31:2] - TIMER_BASE[31:2];
    assign tmr_hit = !ram_hit && (tmr_off < 30'd3);
    assign tmr_we  = tmr_hit && (m_data_byteen == 4'hF);

    dbr_timer u_timer (
        .clk_i   (clk),
        .rst_ni  (reset),
        .we_i    (tmr_we),
        .sel_i   (tmr_off[1:0]),
        .wdata_i (m_data_wdata),
        .rdata_o (tmr_rdata),
        .irq_o   (irq)
    );
`else
    logic [31:0] unused_base;

    assign unused_base = TIMER_BASE;
    assign tmr_hit     = 1'b0;
    assign tmr_rdata   = '0;
    assign irq         = 1'b0;
`endif

    always_comb begin
        m_data_rdata = '0;
        if (ram_hit) begin
            m_data_rdata = mem_q[ram_idx];
        end else if (tmr_hit) begin
            m_data_rdata = tmr_rdata;
        end
    end

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder with a scoreboard of expected reads and irq levels.
module tb_data_bus_responder;

    localparam logic [31:0] TmrCtrl   = 32'h0000_7F00;
    localparam logic [31:0] TmrPreset = 32'h0000_7F04;
    localparam logic [31:0] TmrCount  = 32'h0000_7F08;

    logic        clk;
    logic        reset;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_inst_addr;
    logic [31:0] m_data_rdata;
    logic        irq;

    int unsigned vectors;
    int unsigned miscompares;
    logic [31:0] exp_q [$];
    string       tag_q [$];

    data_bus_responder dut (
        .clk           (clk),
        .reset         (reset),
        .m_data_addr   (m_data_addr),
        .m_data_wdata  (m_data_wdata),
        .m_data_byteen (m_data_byteen),
        .m_inst_addr   (m_inst_addr),
        .m_data_rdata  (m_data_rdata),
        .irq           (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    task automatic pop_cmp(input logic [31:0] obs);
        logic [31:0] exp;
        string       tag;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL sb_empty: observed %h with no expected value queued", obs);
        end else begin
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            assert (obs === exp) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        m_data_addr   = a;
        m_data_wdata  = d;
        m_data_byteen = be;
        @(posedge clk);
        #1;
        m_data_byteen = 4'h0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        @(negedge clk);
        m_data_addr   = a;
        m_data_byteen = 4'h0;
        push(tag, exp);
        #1;
        pop_cmp(m_data_rdata);
    endtask

    initial begin
`ifdef DBR_TIMER_EN
        int cnt_os [6]   = '{3, 3, 2, 1, 0, 0};
        int irq_os [6]   = '{0, 0, 0, 0, 1, 1};
        int cnt_ar [10]  = '{2, 2, 1, 0, 0, 2, 1, 0, 0, 2};
        int irq_ar [10]  = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
`endif
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b0;
        m_data_addr   = '0;
        m_data_wdata  = '0;
        m_data_byteen = 4'h0;
        m_inst_addr   = 32'h0000_3000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Reset state
        rd(32'h10, 32'h0, "rst_ram");
        push("rst_irq", 32'h0);
        pop_cmp({31'd0, irq});

        // RAM full, partial and empty writes
        wr(32'h10, 32'h1234_5678, 4'hF);
        rd(32'h10, 32'h1234_5678, "ram_full");
        rd(32'h14, 32'h0, "ram_neighbour");
        wr(32'h10, 32'h00AB_0000, 4'b0100);
        rd(32'h10, 32'h12AB_5678, "ram_lane2");
        wr(32'h10, 32'hFFFF_FFFF, 4'b0000);
        rd(32'h10, 32'h12AB_5678, "ram_no_be");
        wr(32'h10, 32'hEEEE_EE11, 4'b0001);
        rd(32'h10, 32'h12AB_5611, "ram_lane0");
        wr(32'h2FFC, 32'hA5A5_5A5A, 4'hF);
        rd(32'h2FFC, 32'hA5A5_5A5A, "ram_last_word");

        // Miss just above RAM
        wr(32'h3000, 32'hDEAD_BEEF, 4'hF);
        rd(32'h3000, 32'h0, "miss_read");
        rd(32'h0, 32'h0, "miss_word0");
        rd(32'h2FFC, 32'hA5A5_5A5A, "miss_last_word");

        // Read during write sees pre-edge data
        @(negedge clk);
        m_data_addr   = 32'h10;
        m_data_wdata  = 32'hCAFE_F00D;
        m_data_byteen = 4'hF;
        push("rdw_old", 32'h12AB_5611);
        #1;
        pop_cmp(m_data_rdata);
        @(posedge clk);
        #1;
        m_data_byteen = 4'h0;
        push("rdw_new", 32'hCAFE_F00D);
        pop_cmp(m_data_rdata);

`ifdef DBR_TIMER_EN
        // PRESET write, partial write ignored
        wr(TmrPreset, 32'd3, 4'hF);
        wr(TmrPreset, 32'd7, 4'h3);
        rd(TmrPreset, 32'd3, "preset_partial");

        // One-shot with IM
        wr(TmrCtrl, 32'h9, 4'hF);
        m_data_addr = TmrCount;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            push($sformatf("os_cnt_e%0d", k + 1), 32'(cnt_os[k]));
            push($sformatf("os_irq_e%0d", k + 1), 32'(irq_os[k]));
            pop_cmp(m_data_rdata);
            pop_cmp({31'd0, irq});
        end
        rd(TmrCtrl, 32'h8, "os_ctrl_en_clr");
        wr(TmrCtrl, 32'h0, 4'hF);
        push("os_irq_clear", 32'h0);
        pop_cmp({31'd0, irq});

        // Auto-reload with IM
        wr(TmrPreset, 32'd2, 4'hF);
        wr(TmrCtrl, 32'hB, 4'hF);
        m_data_addr = TmrCount;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            push($sformatf("ar_cnt_e%0d", k + 1), 32'(cnt_ar[k]));
            push($sformatf("ar_irq_e%0d", k + 1), 32'(irq_ar[k]));
            pop_cmp(m_data_rdata);
            pop_cmp({31'd0, irq});
        end
        wr(TmrCtrl, 32'h0, 4'hF);
        repeat (3) @(posedge clk);

        // Reset mid-count at COUNT=5
        wr(TmrPreset, 32'd10, 4'hF);
        wr(TmrCtrl, 32'h9, 4'hF);
        m_data_addr = TmrCount;
        repeat (7) @(posedge clk);
        #1;
        push("mid_cnt5", 32'd5);
        pop_cmp(m_data_rdata);
        @(negedge clk);
        reset = 1'b0;
        #1;
        push("rst_cnt", 32'h0);
        pop_cmp(m_data_rdata);
        push("rst_irq_mid", 32'h0);
        pop_cmp({31'd0, irq});
        m_data_addr = TmrCtrl;
        #1;
        push("rst_ctrl", 32'h0);
        pop_cmp(m_data_rdata);
`else
        // Timer addresses are misses in this build
        wr(TmrCtrl, 32'h9, 4'hF);
        wr(TmrPreset, 32'd3, 4'hF);
        rd(TmrCtrl, 32'h0, "notmr_ctrl");
        rd(TmrPreset, 32'h0, "notmr_preset");
        repeat (8) @(posedge clk);
        #1;
        push("notmr_irq", 32'h0);
        pop_cmp({31'd0, irq});
        @(negedge clk);
        reset = 1'b0;
`endif
        m_data_addr = 32'h10;
        #1;
        push("rst_ram_mid", 32'h0);
        pop_cmp(m_data_rdata);
        @(negedge clk);
        reset = 1'b1;
        rd(32'h2FFC, 32'h0, "rst_ram_last");

`ifdef DBR_TIMER_EN
        // After release the FSM idles until EN is written
        m_data_addr = TmrCount;
        repeat (3) @(posedge clk);
        #1;
        push("post_rst_cnt", 32'h0);
        pop_cmp(m_data_rdata);
        wr(TmrPreset, 32'd4, 4'hF);
        rd(TmrCount, 32'h0, "post_rst_idle");
        wr(TmrCtrl, 32'h1, 4'hF);
        m_data_addr = TmrCount;
        @(posedge clk);
        #1;
        push("restart_load", 32'd4);
        pop_cmp(m_data_rdata);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
